// File: rtl/multi_list_buffer_pkg.sv
// Shared definitions for the multi-list buffer and its neighbouring arbiter blocks:
// width helper and the reset ordering of the free list.
package multi_list_pkg;

    // Free list starts at entry 0 and is linked in ascending order.
    localparam int FREE_HEAD_RESET = 0;

    // $clog2 with a floor of 1 so a single-list build still gets a 1-bit select.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Reset value of next[j]: entries chained in order, last entry wraps to 0.
    function automatic int reset_next(input int j, input int n);
        return (j + 1) % n;
    endfunction

endpackage

// File: rtl/multi_list_buffer_if.sv
// Push/pop request and status bundle between the ingress classifier (master)
// and the multi-list buffer (slave).
interface multi_list_buffer_if
    import multi_list_pkg::*;
#(
    parameter int NUM_ELEMS  = 8,
    parameter int NUM_LISTS  = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int LIST_WIDTH = clog2_min1(NUM_LISTS);
    localparam int CNT_WIDTH  = $clog2(NUM_ELEMS + 1);

    logic                            push_valid;
    logic [LIST_WIDTH-1:0]           push_list;
    logic [DATA_WIDTH-1:0]           push_data;
    logic                            pop_valid;
    logic [LIST_WIDTH-1:0]           pop_list;
    logic                            pop_data_valid;
    logic [DATA_WIDTH-1:0]           pop_data;
    logic                            full;
    logic [NUM_LISTS-1:0]            empty;
    logic [NUM_LISTS*CNT_WIDTH-1:0]  list_count;
    logic [CNT_WIDTH-1:0]            free_count;
    logic                            overflow;
    logic                            underflow;

    modport master (
        output push_valid, push_list, push_data, pop_valid, pop_list,
        input  pop_data_valid, pop_data, full, empty, list_count, free_count,
               overflow, underflow
    );

    modport slave (
        input  push_valid, push_list, push_data, pop_valid, pop_list,
        output pop_data_valid, pop_data, full, empty, list_count, free_count,
               overflow, underflow
    );

endinterface

// File: rtl/multi_list_mem.sv
// Entry storage: payload plus next pointer per entry. One payload write port,
// two next-pointer write ports (list link and free-list link, never the same
// entry in one cycle) and two combinational read ports.
module multi_list_mem
    import multi_list_pkg::*;
#(
    parameter int NUM_ELEMS  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_we,
    input  logic [PTR_WIDTH-1:0]  data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  link_we,
    input  logic [PTR_WIDTH-1:0]  link_addr,
    input  logic [PTR_WIDTH-1:0]  link_wdata,
    input  logic                  free_we,
    input  logic [PTR_WIDTH-1:0]  free_addr,
    input  logic [PTR_WIDTH-1:0]  free_wdata,
    input  logic [PTR_WIDTH-1:0]  rd_a_addr,
    output logic [PTR_WIDTH-1:0]  rd_a_next,
    input  logic [PTR_WIDTH-1:0]  rd_b_addr,
    output logic [DATA_WIDTH-1:0] rd_b_data,
    output logic [PTR_WIDTH-1:0]  rd_b_next
);

    logic [DATA_WIDTH-1:0] data_mem [NUM_ELEMS];
    logic [PTR_WIDTH-1:0]  next_mem [NUM_ELEMS];

    // Payload write; contents need no reset since counts gate every read.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_addr] <= data_wdata;
        end
    end

    // Next pointers: reset builds the initial free chain, then two link writers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_ELEMS; j++) begin
                next_mem[j] <= PTR_WIDTH'(reset_next(j, NUM_ELEMS));
            end
        end else begin
            if (link_we) begin
                next_mem[link_addr] <= link_wdata;
            end
            if (free_we) begin
                next_mem[free_addr] <= free_wdata;
            end
        end
    end

    assign rd_a_next = next_mem[rd_a_addr];
    assign rd_b_data = data_mem[rd_b_addr];
    assign rd_b_next = next_mem[rd_b_addr];

endmodule

// File: rtl/multi_list_buffer.sv
// NUM_LISTS FIFO queues sharing one pool of linked entries with an internal
// free list. One push and one pop per cycle on any lists; registered pop data.
module multi_list_buffer
    import multi_list_pkg::*;
#(
    parameter int NUM_ELEMS  = 8,
    parameter int NUM_LISTS  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    multi_list_buffer_if.slave bus
);

    localparam int PTR_WIDTH  = $clog2(NUM_ELEMS);
    localparam int LIST_WIDTH = clog2_min1(NUM_LISTS);
    localparam int CNT_WIDTH  = $clog2(NUM_ELEMS + 1);

    localparam logic [LIST_WIDTH:0]  LIST_LIMIT = (LIST_WIDTH + 1)'(NUM_LISTS);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ALL    = CNT_WIDTH'(NUM_ELEMS);

    // Per-list state gathered into arrays for indexed access.
    logic [PTR_WIDTH-1:0]  head_arr  [NUM_LISTS];
    logic [PTR_WIDTH-1:0]  tail_arr  [NUM_LISTS];
    logic [CNT_WIDTH-1:0]  count_arr [NUM_LISTS];

    logic [PTR_WIDTH-1:0]  free_head_reg, free_head_next;
    logic [PTR_WIDTH-1:0]  free_tail_reg, free_tail_next;
    logic [CNT_WIDTH-1:0]  free_count_reg, free_count_next;

    logic                  pop_data_valid_reg;
    logic [DATA_WIDTH-1:0] pop_data_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic                  full;
    logic                  push_in_range, pop_in_range;
    logic [LIST_WIDTH-1:0] push_sel, pop_sel;
    logic                  push_acc, pop_acc;
    logic [PTR_WIDTH-1:0]  pop_head, push_tail;
    logic [CNT_WIDTH-1:0]  pop_count, push_count;
    logic                  link_we, free_we;

    logic [PTR_WIDTH-1:0]  free_next;
    logic [DATA_WIDTH-1:0] pop_rdata;
    logic [PTR_WIDTH-1:0]  pop_next;

    assign full = (free_count_reg == CNT_ZERO);

    // Request decode: range checks, clamped selects and acceptance.
    always_comb begin
        push_in_range = ({1'b0, bus.push_list} < LIST_LIMIT);
        pop_in_range  = ({1'b0, bus.pop_list} < LIST_LIMIT);
        push_sel      = push_in_range ? bus.push_list : '0;
        pop_sel       = pop_in_range ? bus.pop_list : '0;
        pop_head      = head_arr[pop_sel];
        pop_count     = count_arr[pop_sel];
        push_tail     = tail_arr[push_sel];
        push_count    = count_arr[push_sel];
        push_acc      = bus.push_valid & ~full & push_in_range;
        pop_acc       = bus.pop_valid & pop_in_range & (pop_count != CNT_ZERO);
        // Link the new entry behind the tail unless the list is being replaced
        // wholesale (count 1 popped and pushed together) or starts empty.
        link_we       = push_acc & (push_count != CNT_ZERO) &
                        ~(pop_acc & (pop_sel == push_sel) & (push_count == CNT_ONE));
    end

    // Free list: take from head on push, append freed entry on pop.
    always_comb begin
        free_head_next  = free_head_reg;
        free_tail_next  = free_tail_reg;
        free_count_next = free_count_reg;
        free_we         = 1'b0;
        if (push_acc && pop_acc) begin
            if (free_count_reg == CNT_ONE) begin
                // Only free entry is taken; the returned one becomes the sole entry.
                free_head_next = pop_head;
                free_tail_next = pop_head;
            end else begin
                free_head_next = free_next;
                free_tail_next = pop_head;
                free_we        = 1'b1;
            end
        end else if (push_acc) begin
            free_head_next  = free_next;
            free_count_next = free_count_reg - CNT_ONE;
        end else if (pop_acc) begin
            if (free_count_reg == CNT_ZERO) begin
                free_head_next = pop_head;
            end else begin
                free_we = 1'b1;
            end
            free_tail_next  = pop_head;
            free_count_next = free_count_reg + CNT_ONE;
        end
    end

    // Free list registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_head_reg  <= PTR_WIDTH'(FREE_HEAD_RESET);
            free_tail_reg  <= PTR_WIDTH'(NUM_ELEMS - 1);
            free_count_reg <= CNT_ALL;
        end else begin
            free_head_reg  <= free_head_next;
            free_tail_reg  <= free_tail_next;
            free_count_reg <= free_count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LISTS; gi++) begin : gen_list
            logic [PTR_WIDTH-1:0] head_reg, head_next;
            logic [PTR_WIDTH-1:0] tail_reg, tail_next;
            logic [CNT_WIDTH-1:0] count_reg, count_next;
            logic                 push_hit, pop_hit;

            assign push_hit = push_acc & (push_sel == LIST_WIDTH'(gi));
            assign pop_hit  = pop_acc & (pop_sel == LIST_WIDTH'(gi));

            // Head/tail/count update for this list.
            always_comb begin
                head_next  = head_reg;
                tail_next  = tail_reg;
                count_next = count_reg;
                case ({push_hit, pop_hit})
                    2'b10: begin
                        if (count_reg == CNT_ZERO) begin
                            head_next = free_head_reg;
                        end
                        tail_next  = free_head_reg;
                        count_next = count_reg + CNT_ONE;
                    end
                    2'b01: begin
                        head_next  = pop_next;
                        count_next = count_reg - CNT_ONE;
                    end
                    2'b11: begin
                        head_next = (count_reg == CNT_ONE) ? free_head_reg : pop_next;
                        tail_next = free_head_reg;
                    end
                    default: ;
                endcase
            end

            // List registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= CNT_ZERO;
                end else begin
                    head_reg  <= head_next;
                    tail_reg  <= tail_next;
                    count_reg <= count_next;
                end
            end

            assign head_arr[gi]  = head_reg;
            assign tail_arr[gi]  = tail_reg;
            assign count_arr[gi] = count_reg;

            assign bus.empty[gi]                                = (count_reg == CNT_ZERO);
            assign bus.list_count[gi*CNT_WIDTH +: CNT_WIDTH]    = count_reg;
        end
    endgenerate

    // Registered pop result; data holds its last value between pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data_valid_reg <= 1'b0;
            pop_data_reg       <= '0;
        end else begin
            pop_data_valid_reg <= pop_acc;
            if (pop_acc) begin
                pop_data_reg <= pop_rdata;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (bus.push_valid && !push_acc) begin
                overflow_reg <= 1'b1;
            end
            if (bus.pop_valid && !pop_acc) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    multi_list_mem #(
        .NUM_ELEMS  (NUM_ELEMS),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .data_we    (push_acc),
        .data_addr  (free_head_reg),
        .data_wdata (bus.push_data),
        .link_we    (link_we),
        .link_addr  (push_tail),
        .link_wdata (free_head_reg),
        .free_we    (free_we),
        .free_addr  (free_tail_reg),
        .free_wdata (pop_head),
        .rd_a_addr  (free_head_reg),
        .rd_a_next  (free_next),
        .rd_b_addr  (pop_head),
        .rd_b_data  (pop_rdata),
        .rd_b_next  (pop_next)
    );

    assign bus.full           = full;
    assign bus.free_count     = free_count_reg;
    assign bus.pop_data_valid = pop_data_valid_reg;
    assign bus.pop_data       = pop_data_reg;
    assign bus.overflow       = overflow_reg;
    assign bus.underflow      = underflow_reg;

endmodule

// File: tb/tb_multi_list_buffer.sv
// Directed vector table, an out-of-range sequence on a 3-list build, and a
// random run against per-list reference queues with a mid-run reset.
module tb_multi_list_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_list_buffer_if #(.NUM_ELEMS(8), .NUM_LISTS(4), .DATA_WIDTH(16)) bus_a ();
    multi_list_buffer_if #(.NUM_ELEMS(8), .NUM_LISTS(3), .DATA_WIDTH(16)) bus_b ();

    multi_list_buffer #(.NUM_ELEMS(8), .NUM_LISTS(4), .DATA_WIDTH(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    multi_list_buffer #(.NUM_ELEMS(8), .NUM_LISTS(3), .DATA_WIDTH(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic        pv;
        logic [1:0]  pl;
        logic [15:0] pd;
        logic        ov;
        logic [1:0]  ol;
        logic        e_pdv;
        logic [15:0] e_pdata;
        logic [3:0]  e_free;
        logic        e_full;
        logic [3:0]  e_empty;
        logic [15:0] e_cnt;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic pv, input logic [1:0] pl, input logic [15:0] pd,
                                input logic ov, input logic [1:0] ol,
                                input logic e_pdv, input logic [15:0] e_pdata,
                                input logic [3:0] e_free, input logic e_full,
                                input logic [3:0] e_empty, input logic [15:0] e_cnt,
                                input logic e_ovf, input logic e_udf);
        vec_t v;
        v.pv = pv; v.pl = pl; v.pd = pd; v.ov = ov; v.ol = ol;
        v.e_pdv = e_pdv; v.e_pdata = e_pdata; v.e_free = e_free; v.e_full = e_full;
        v.e_empty = e_empty; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic pv, input logic [1:0] pl, input logic [15:0] pd,
                           input logic ov, input logic [1:0] ol);
        bus_a.push_valid = pv;
        bus_a.push_list  = pl;
        bus_a.push_data  = pd;
        bus_a.pop_valid  = ov;
        bus_a.pop_list   = ol;
    endtask

    task automatic drive_b(input logic pv, input logic [1:0] pl, input logic [15:0] pd,
                           input logic ov, input logic [1:0] ol);
        bus_b.push_valid = pv;
        bus_b.push_list  = pl;
        bus_b.push_data  = pd;
        bus_b.pop_valid  = ov;
        bus_b.pop_list   = ol;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_free"},  32'(bus_a.free_count), 32'd8);
        chk({tag, "_empty"}, 32'(bus_a.empty), 32'hF);
        chk({tag, "_cnt"},   32'(bus_a.list_count), 32'h0);
        chk({tag, "_full"},  32'(bus_a.full), 32'd0);
        chk({tag, "_pdv"},   32'(bus_a.pop_data_valid), 32'd0);
        chk({tag, "_pdata"}, 32'(bus_a.pop_data), 32'h0);
        chk({tag, "_ovf"},   32'(bus_a.overflow), 32'd0);
        chk({tag, "_udf"},   32'(bus_a.underflow), 32'd0);
    endtask

    // Reference model for the random run.
    logic [15:0] mq [4][$];
    logic [15:0] m_pdata;
    logic        m_ovf, m_udf;

    initial begin
        vec_t v;
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);

        //            pv pl pd      ov ol  pdv pdata    free full empty    cnt      ovf udf
        vecs[0]  = mk(1, 2, 16'hA1, 0, 0,  0, 16'h00,   8'd7, 0, 4'b1011, 16'h0100, 0, 0);
        vecs[1]  = mk(1, 2, 16'hA2, 0, 0,  0, 16'h00,   8'd6, 0, 4'b1011, 16'h0200, 0, 0);
        vecs[2]  = mk(0, 0, 16'h00, 1, 2,  1, 16'hA1,   8'd7, 0, 4'b1011, 16'h0100, 0, 0);
        vecs[3]  = mk(0, 0, 16'h00, 1, 2,  1, 16'hA2,   8'd8, 0, 4'b1111, 16'h0000, 0, 0);
        vecs[4]  = mk(0, 0, 16'h00, 0, 0,  0, 16'hA2,   8'd8, 0, 4'b1111, 16'h0000, 0, 0);
        vecs[5]  = mk(1, 0, 16'h10, 0, 0,  0, 16'hA2,   8'd7, 0, 4'b1110, 16'h0001, 0, 0);
        vecs[6]  = mk(1, 1, 16'h11, 0, 0,  0, 16'hA2,   8'd6, 0, 4'b1100, 16'h0011, 0, 0);
        vecs[7]  = mk(1, 0, 16'h12, 0, 0,  0, 16'hA2,   8'd5, 0, 4'b1100, 16'h0012, 0, 0);
        vecs[8]  = mk(1, 1, 16'h13, 0, 0,  0, 16'hA2,   8'd4, 0, 4'b1100, 16'h0022, 0, 0);
        vecs[9]  = mk(1, 0, 16'h14, 0, 0,  0, 16'hA2,   8'd3, 0, 4'b1100, 16'h0023, 0, 0);
        vecs[10] = mk(1, 1, 16'h15, 0, 0,  0, 16'hA2,   8'd2, 0, 4'b1100, 16'h0033, 0, 0);
        vecs[11] = mk(1, 0, 16'h16, 0, 0,  0, 16'hA2,   8'd1, 0, 4'b1100, 16'h0034, 0, 0);
        vecs[12] = mk(1, 1, 16'h17, 0, 0,  0, 16'hA2,   8'd0, 1, 4'b1100, 16'h0044, 0, 0);
        vecs[13] = mk(1, 2, 16'hEE, 0, 0,  0, 16'hA2,   8'd0, 1, 4'b1100, 16'h0044, 1, 0);
        vecs[14] = mk(1, 3, 16'h77, 1, 0,  1, 16'h10,   8'd1, 0, 4'b1100, 16'h0043, 1, 0);
        vecs[15] = mk(0, 0, 16'h00, 1, 1,  1, 16'h11,   8'd2, 0, 4'b1100, 16'h0033, 1, 0);
        vecs[16] = mk(0, 0, 16'h00, 1, 1,  1, 16'h13,   8'd3, 0, 4'b1100, 16'h0023, 1, 0);
        vecs[17] = mk(0, 0, 16'h00, 1, 1,  1, 16'h15,   8'd4, 0, 4'b1100, 16'h0013, 1, 0);
        vecs[18] = mk(1, 1, 16'h66, 1, 1,  1, 16'h17,   8'd4, 0, 4'b1100, 16'h0013, 1, 0);
        vecs[19] = mk(0, 0, 16'h00, 1, 1,  1, 16'h66,   8'd5, 0, 4'b1110, 16'h0003, 1, 0);
        vecs[20] = mk(1, 0, 16'h99, 1, 0,  1, 16'h12,   8'd5, 0, 4'b1110, 16'h0003, 1, 0);
        vecs[21] = mk(0, 0, 16'h00, 1, 0,  1, 16'h14,   8'd6, 0, 4'b1110, 16'h0002, 1, 0);
        vecs[22] = mk(0, 0, 16'h00, 1, 0,  1, 16'h16,   8'd7, 0, 4'b1110, 16'h0001, 1, 0);
        vecs[23] = mk(0, 0, 16'h00, 1, 0,  1, 16'h99,   8'd8, 0, 4'b1111, 16'h0000, 1, 0);
        vecs[24] = mk(0, 0, 16'h00, 1, 0,  0, 16'h99,   8'd8, 0, 4'b1111, 16'h0000, 1, 1);
        vecs[25] = mk(1, 3, 16'h33, 1, 3,  0, 16'h99,   8'd7, 0, 4'b0111, 16'h1000, 1, 1);
        vecs[26] = mk(1, 2, 16'h44, 1, 3,  1, 16'h33,   8'd7, 0, 4'b1011, 16'h0100, 1, 1);
        vecs[27] = mk(0, 0, 16'h00, 1, 2,  1, 16'h44,   8'd8, 0, 4'b1111, 16'h0000, 1, 1);

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_reset_a("reset");
        $display("reset: free=%0d empty=%b", bus_a.free_count, bus_a.empty);

        // Directed table
        for (int i = 0; i < 28; i++) begin
            v = vecs[i];
            drive_a(v.pv, v.pl, v.pd, v.ov, v.ol);
            step();
            $display("vec %0d: push=%0b/%0d/%0h pop=%0b/%0d -> pdv=%0b pdata=%0h free=%0d cnt=%0h",
                     i, v.pv, v.pl, v.pd, v.ov, v.ol, bus_a.pop_data_valid, bus_a.pop_data,
                     bus_a.free_count, bus_a.list_count);
            chk($sformatf("vec%0d_pdv", i),   32'(bus_a.pop_data_valid), 32'(v.e_pdv));
            chk($sformatf("vec%0d_pdata", i), 32'(bus_a.pop_data), 32'(v.e_pdata));
            chk($sformatf("vec%0d_free", i),  32'(bus_a.free_count), 32'(v.e_free));
            chk($sformatf("vec%0d_full", i),  32'(bus_a.full), 32'(v.e_full));
            chk($sformatf("vec%0d_empty", i), 32'(bus_a.empty), 32'(v.e_empty));
            chk($sformatf("vec%0d_cnt", i),   32'(bus_a.list_count), 32'(v.e_cnt));
            chk($sformatf("vec%0d_ovf", i),   32'(bus_a.overflow), 32'(v.e_ovf));
            chk($sformatf("vec%0d_udf", i),   32'(bus_a.underflow), 32'(v.e_udf));
        end
        drive_a(0, 0, 0, 0, 0);

        // Out-of-range list indices on the 3-list build (index 3 is invalid)
        drive_b(1, 3, 16'h12, 0, 0);
        step();
        $display("range: push list 3 -> ovf=%0b free=%0d", bus_b.overflow, bus_b.free_count);
        chk("range_push_ovf",  32'(bus_b.overflow), 32'd1);
        chk("range_push_free", 32'(bus_b.free_count), 32'd8);
        chk("range_push_cnt",  32'(bus_b.list_count), 32'h0);
        drive_b(1, 0, 16'h21, 0, 0);
        step();
        $display("range: push list 0 -> free=%0d", bus_b.free_count);
        chk("range_push0_free", 32'(bus_b.free_count), 32'd7);
        chk("range_push0_udf",  32'(bus_b.underflow), 32'd0);
        drive_b(0, 0, 0, 1, 3);
        step();
        $display("range: pop list 3 -> udf=%0b pdv=%0b", bus_b.underflow, bus_b.pop_data_valid);
        chk("range_pop_udf",  32'(bus_b.underflow), 32'd1);
        chk("range_pop_pdv",  32'(bus_b.pop_data_valid), 32'd0);
        chk("range_pop_free", 32'(bus_b.free_count), 32'd7);
        chk("range_pop_cnt",  32'(bus_b.list_count), 32'h1);
        drive_b(0, 0, 0, 1, 0);
        step();
        $display("range: pop list 0 -> pdv=%0b pdata=%0h", bus_b.pop_data_valid, bus_b.pop_data);
        chk("range_pop0_pdv",   32'(bus_b.pop_data_valid), 32'd1);
        chk("range_pop0_pdata", 32'(bus_b.pop_data), 32'h21);
        drive_b(0, 0, 0, 0, 0);

        // Random run against reference queues, reset at cycle 700
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_a("rand_start");
        for (int q = 0; q < 4; q++) mq[q].delete();
        m_pdata = 16'h0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic        pv, ov, e_pdv;
            logic [1:0]  pl, ol;
            logic [15:0] pd, e_cnt;
            logic [3:0]  e_empty;
            int          total, sum;
            pv = ($urandom_range(0, 99) < 55);
            ov = ($urandom_range(0, 99) < 50);
            pl = 2'($urandom_range(0, 3));
            ol = 2'($urandom_range(0, 3));
            pd = 16'($urandom);
            drive_a(pv, pl, pd, ov, ol);
            if (cyc == 700) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                $display("rand %0d: reset asserted with push=%0b pop=%0b", cyc, pv, ov);
                chk_reset_a("midrst");
                for (int q = 0; q < 4; q++) mq[q].delete();
                m_pdata = 16'h0;
                m_ovf = 1'b0;
                m_udf = 1'b0;
                continue;
            end
            total = 0;
            for (int q = 0; q < 4; q++) total += mq[q].size();
            e_pdv = 1'b0;
            if (ov) begin
                if (mq[ol].size() > 0) begin
                    e_pdv = 1'b1;
                    m_pdata = mq[ol].pop_front();
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (pv) begin
                if (total < 8) mq[pl].push_back(pd);
                else m_ovf = 1'b1;
            end
            total = 0;
            e_cnt = 16'h0;
            for (int q = 0; q < 4; q++) begin
                total += mq[q].size();
                e_cnt[q*4 +: 4] = 4'(mq[q].size());
                e_empty[q] = (mq[q].size() == 0);
            end
            step();
            $display("rand %0d: push=%0b/%0d pop=%0b/%0d -> pdv=%0b pdata=%0h free=%0d cnt=%0h",
                     cyc, pv, pl, ov, ol, bus_a.pop_data_valid, bus_a.pop_data,
                     bus_a.free_count, bus_a.list_count);
            chk("rand_pdv",   32'(bus_a.pop_data_valid), 32'(e_pdv));
            chk("rand_pdata", 32'(bus_a.pop_data), 32'(m_pdata));
            chk("rand_free",  32'(bus_a.free_count), 32'(8 - total));
            chk("rand_cnt",   32'(bus_a.list_count), 32'(e_cnt));
            chk("rand_empty", 32'(bus_a.empty), 32'(e_empty));
            chk("rand_full",  32'(bus_a.full), 32'(total == 8));
            chk("rand_ovf",   32'(bus_a.overflow), 32'(m_ovf));
            chk("rand_udf",   32'(bus_a.underflow), 32'(m_udf));
            sum = int'(bus_a.free_count);
            for (int q = 0; q < 4; q++) sum += int'(bus_a.list_count[q*4 +: 4]);
            chk("rand_sum", 32'(sum), 32'd8);
        end
        drive_a(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
